// File: rtl/alpha_order_sequencer.sv
// alpha_order_sequencer
//
// This block sits between the alpha core signal strobe and the exchange TX
// gateway. It turns single-cycle BUY/SELL pulses into one-lot orders on a
// valid/ready handshake. It enforces a signed position limit and a cooldown
// window after each strategy order, and it counts dropped signals. When
// flatten is requested, it drives the position back to zero one lot at a time.
//
// Ports:
//   clk          system clock; all logic runs on its rising edge
//   reset        synchronous, active-high
//   enable       strategy kill switch; low means strategy signals are ignored
//   sig_valid    one-cycle strategy signal strobe
//   sig_code     01 = BUY, 10 = SELL, other codes mean no action
//   sig_price    tick price that comes with the signal
//   flatten_req  level request to drive the position to zero
//   ord_valid    order presented to the gateway
//   ord_side     0 = BUY, 1 = SELL
//   ord_price    order price
//   ord_ready    gateway accepts the order when this and ord_valid are high
//   position     signed net position in lots (two's complement)
//   rej_count    saturating count of dropped actionable signals
//   busy         high whenever the FSM is not idle
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | waiting for a strategy signal or a flatten request
// S_SEND     | strategy order presented, waiting for the handshake
// S_COOLDOWN | throttle window after an accepted strategy order
// S_FLATTEN  | one-lot orders that drive the position to zero

module alpha_order_sequencer #(
    parameter int MAX_POS         = 4,
    parameter int THROTTLE_CYCLES = 8,
    parameter int PX_W            = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            sig_valid,
    input  logic [1:0]      sig_code,
    input  logic [PX_W-1:0] sig_price,
    input  logic            flatten_req,
    output logic            ord_valid,
    output logic            ord_side,
    output logic [PX_W-1:0] ord_price,
    input  logic            ord_ready,
    output logic [7:0]      position,
    output logic [15:0]     rej_count,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEND     = 2'd1,
        S_COOLDOWN = 2'd2,
        S_FLATTEN  = 2'd3
    } state_t;

    localparam logic signed [7:0] POS_LIM = 8'(MAX_POS);
    localparam logic [7:0]        THR     = 8'(THROTTLE_CYCLES);

    state_t             state_q, state_d;
    logic               ord_valid_q, ord_valid_d;
    logic               ord_side_q, ord_side_d;
    logic [PX_W-1:0]    ord_price_q, ord_price_d;
    logic signed [7:0]  position_q, position_d;
    logic [15:0]        rej_q, rej_d;
    logic               pend_q, pend_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               busy_q;

    logic               act;
    logic               is_buy;
    logic               limit_ok;
    logic               handshake;
    logic signed [7:0]  pos_after;
    logic               rej_inc;

    assign act       = sig_valid && (sig_code == 2'b01 || sig_code == 2'b10);
    assign is_buy    = (sig_code == 2'b01);
    assign limit_ok  = is_buy ? (position_q < POS_LIM) : (position_q > -POS_LIM);
    assign handshake = ord_valid_q && ord_ready;
    // The order in flight always moves the position by one lot in the
    // direction of its side. This applies to both strategy and flatten orders.
    assign pos_after = ord_side_q ? (position_q - 8'sd1) : (position_q + 8'sd1);

    always_comb begin
        state_d     = state_q;
        ord_valid_d = ord_valid_q;
        ord_side_d  = ord_side_q;
        ord_price_d = ord_price_q;
        position_d  = position_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        rej_inc     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (flatten_req && position_q != 8'sd0) begin
                    // Flatten takes priority. A signal that arrives in the
                    // same cycle is lost, so it is counted as dropped.
                    state_d     = S_FLATTEN;
                    ord_valid_d = 1'b1;
                    ord_side_d  = (position_q > 8'sd0);
                    pend_d      = 1'b0;
                    rej_inc     = act;
                end else if (act && enable) begin
                    if (limit_ok) begin
                        state_d     = S_SEND;
                        ord_valid_d = 1'b1;
                        ord_side_d  = !is_buy;
                        ord_price_d = sig_price;
                    end else begin
                        rej_inc = 1'b1;
                    end
                end
            end

            S_SEND: begin
                rej_inc = act;
                if (flatten_req) begin
                    pend_d = 1'b1;
                end
                if (handshake) begin
                    position_d = pos_after;
                    pend_d     = 1'b0;
                    if ((pend_q || flatten_req) && pos_after != 8'sd0) begin
                        // Keep ord_valid high and continue straight into
                        // the flatten orders.
                        state_d    = S_FLATTEN;
                        ord_side_d = (pos_after > 8'sd0);
                    end else begin
                        ord_valid_d = 1'b0;
                        if (THR != 8'd0) begin
                            state_d = S_COOLDOWN;
                            cnt_d   = THR;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end

            S_COOLDOWN: begin
                rej_inc = act;
                if (flatten_req && position_q != 8'sd0) begin
                    state_d     = S_FLATTEN;
                    ord_valid_d = 1'b1;
                    ord_side_d  = (position_q > 8'sd0);
                    pend_d      = 1'b0;
                    cnt_d       = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        state_d = S_IDLE;
                        cnt_d   = 8'd0;
                    end
                end
            end

            S_FLATTEN: begin
                rej_inc = act;
                if (handshake) begin
                    position_d = pos_after;
                    if (pos_after == 8'sd0) begin
                        state_d     = S_IDLE;
                        ord_valid_d = 1'b0;
                    end else begin
                        ord_side_d = (pos_after > 8'sd0);
                    end
                end
            end

            default: begin
                state_d     = S_IDLE;
                ord_valid_d = 1'b0;
            end
        endcase

        rej_d = (rej_inc && rej_q != 16'hFFFF) ? (rej_q + 16'd1) : rej_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ord_valid_q <= 1'b0;
            ord_side_q  <= 1'b0;
            ord_price_q <= '0;
            position_q  <= 8'sd0;
            rej_q       <= 16'd0;
            pend_q      <= 1'b0;
            cnt_q       <= 8'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ord_valid_q <= ord_valid_d;
            ord_side_q  <= ord_side_d;
            ord_price_q <= ord_price_d;
            position_q  <= position_d;
            rej_q       <= rej_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign ord_valid = ord_valid_q;
    assign ord_side  = ord_side_q;
    assign ord_price = ord_price_q;
    assign position  = position_q;
    assign rej_count = rej_q;
    assign busy      = busy_q;

endmodule

// File: doc/alpha_order_sequencer.md
# alpha_order_sequencer

Order sequencer placed between the alpha core's `order_signal`/`order_valid` outputs and the exchange TX gateway. It turns single-cycle BUY/SELL pulses into one-lot orders on a valid/ready handshake. It enforces a signed position limit and a post-order throttle window, counts dropped signals, and on request flattens the book one lot at a time.

## Interface
- `MAX_POS`, 4: absolute position limit in lots; legal range 1..127.
- `THROTTLE_CYCLES`, 8: cooldown cycles after each accepted strategy order; 0 disables cooldown; legal range 0..255.
- `PX_W`, 32: price width.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  strategy kill switch; low means strategy signals are ignored.
- `sig_valid`  in  1  one-cycle strategy signal strobe, from the alpha core `order_valid`.
- `sig_code`  in  2  01 = BUY, 10 = SELL; 00 and 11 = no action.
- `sig_price`  in  PX_W  tick price accompanying the signal.
- `flatten_req`  in  1  level-sensitive request to drive position to zero.
- `ord_valid`  out  1  order presented to the gateway.
- `ord_side`  out  1  0 = BUY, 1 = SELL.
- `ord_price`  out  PX_W  order price.
- `ord_ready`  in  1  gateway accepts when high together with `ord_valid`.
- `position`  out  8  signed net position, two's complement.
- `rej_count`  out  16  saturating count of dropped actionable signals.
- `busy`  out  1  high when the FSM is not in IDLE.

## Operation
- States: IDLE, SEND, COOLDOWN, FLATTEN.
- An actionable signal is `sig_valid` with `sig_code` equal to 01 or 10. Other codes are ignored everywhere and are not counted.
- IDLE behaviour, in priority order:
  - `flatten_req` high and `position` ≠ 0: enter FLATTEN.
  - Actionable signal with `enable` high that passes the limit check: latch side and `sig_price`, enter SEND.
  - Limit check: BUY requires `position` < MAX_POS; SELL requires `position` > −MAX_POS.
  - Actionable signal with `enable` high that fails the limit check: `rej_count` +1.
  - Actionable signal with `enable` low: dropped, not counted.
- SEND:
  - `ord_valid`=1 with side and price held stable until handshake; `ord_valid` never drops before `ord_ready`.
  - On handshake, `position` ±1 in the same cycle.
  - Next state after handshake: FLATTEN if a flatten is pending and the updated position ≠ 0. Otherwise COOLDOWN if THROTTLE_CYCLES > 0, else IDLE.
- COOLDOWN:
  - Counter loaded with THROTTLE_CYCLES at the handshake and decremented each cycle.
  - Exit to IDLE on the cycle the counter reads 1, giving THROTTLE_CYCLES cycles in COOLDOWN.
  - `flatten_req` with `position` ≠ 0 aborts the cooldown immediately and enters FLATTEN.
- FLATTEN:
  - `ord_valid`=1. Side is SELL if `position` > 0, BUY if < 0.
  - Price is the last latched order price (0 after reset).
  - Each handshake moves `position` one lot toward 0 with no cooldown. On reaching 0, go to IDLE.
  - Runs regardless of `enable` or `flatten_req` deasserting.
- Pending flatten: `flatten_req` seen high during SEND sets a pending flag. The flag clears on entering FLATTEN or if position is 0 at handshake.
- Actionable signals arriving in SEND, COOLDOWN or FLATTEN are dropped and counted in `rej_count`; no queueing.
- `rej_count` saturates at 0xFFFF.
- `position` never exceeds ±MAX_POS. Arithmetic is 8-bit signed and cannot overflow under the legal parameter range.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values: state IDLE, `ord_valid`=0, `ord_side`=0, `ord_price`=0, `position`=0, `rej_count`=0, `busy`=0, pending flag cleared, counter 0.
- All outputs are registered.
- Accepted signal at edge N (IDLE) → `ord_valid`=1 from cycle N+1.
- Best case, order latency is one cycle. Handshake can complete at edge N+1 if `ord_ready` is already high.
- FLATTEN entry at edge N → `ord_valid`=1 from N+1. With `ord_ready` tied high, one lot completes per cycle.
- Back-to-back strategy orders are separated by at least THROTTLE_CYCLES+1 cycles, measured from handshake edge to next acceptance edge.
- `flatten_req` and an actionable signal in the same IDLE cycle: flatten wins and the signal is counted as dropped.
- Reset asserted mid-SEND or mid-FLATTEN: `ord_valid` is low the next cycle, the order is abandoned, and position is cleared to 0.

## Test plan
- BUY at price 1050 in IDLE with `ord_ready`=1 → `ord_valid` high for exactly one cycle with side 0 and price 1050. `position`=1, then 8 cycles `busy` in COOLDOWN, then IDLE.
- Five BUYs spaced 20 cycles apart, MAX_POS=4 → four orders sent, `position`=4, fifth dropped with `rej_count`=1 and no `ord_valid`.
- `ord_ready` held low 5 cycles during SEND while three more BUY pulses arrive → `ord_valid`, side and price stable throughout. `rej_count`=3, position +1 only at the handshake.
- `position`=3, `flatten_req` pulsed for one cycle, `ord_ready`=1 → three consecutive SELL orders at the last latched price, `position` 3→2→1→0, then IDLE. The `enable`=0 case gives the same result.
- `flatten_req` and a SELL signal in the same cycle with `position`=−2 → two BUY flatten orders, SELL dropped, `rej_count`+1.
- Reset asserted while `ord_valid`=1 and `ord_ready`=0 → next cycle `ord_valid`=0, `position`=0, `rej_count`=0, `busy`=0.
